// File: rtl/types_pkg.sv
// types_pkg: shared bus widths and pipeline-stage state encoding.
package types_pkg;

    localparam int DATA_BUS = 32;
    localparam int ADDR_BUS = 32;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush and bubble counter.
// State is captured on the falling edge to line up with the existing pipeline registers.
module pipe_stage_reg
    import types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              in_xfer, out_xfer;

    assign out_valid_o  = state_q != EMPTY;
    assign in_ready_o   = state_q != TWO;
    assign occupancy_o  = state_q;
    assign out_data_o   = main_data_q;
    assign out_ctrl_o   = out_valid_o ? main_ctrl_q : '0;
    assign bubble_cnt_o = bubble_q;
    assign in_xfer      = in_valid_i && in_ready_o && !flush_i;
    assign out_xfer     = out_valid_o && out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        bubble_d    = (out_ready_i && !out_valid_o && bubble_q != '1) ? bubble_q + 1'b1 : bubble_q;
        if (flush_i) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    main_ctrl_d = in_ctrl_i;
                    main_data_d = in_data_i;
                    state_d     = ONE;
                end
                ONE: if (in_xfer && out_xfer) begin
                    main_ctrl_d = in_ctrl_i;
                    main_data_d = in_data_i;
                end else if (in_xfer) begin
                    skid_ctrl_d = in_ctrl_i;
                    skid_data_d = in_data_i;
                    state_d     = TWO;
                end else if (out_xfer) begin
                    state_d     = EMPTY;
                end
                TWO: if (out_xfer) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    state_d     = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            bubble_q    <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenario bench for pipe_stage_reg (falling-edge design).
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [CTRL_W-1:0] in_ctrl_i = '0;
    logic [DATA_W-1:0] in_data_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
        .occupancy_o(occupancy_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    // Advance past one active (falling) edge; outputs are then stable for sampling.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid_i = v;
        in_data_i  = d;
        in_ctrl_i  = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready_i = 1'b1;
        offer(1'b1, 32'hCAFE_0001, 16'h00FF);
        tick();
        tick();
        rst = 1'b0;
        offer(1'b0, '0, '0);
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
        n_checks++; if (out_ctrl_o !== '0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", out_ctrl_o); end
        n_checks++; if (out_data_o !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data_o); end
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready_o); end
        n_checks++; if (bubble_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_bubble got %0d want 0", bubble_cnt_o); end
    endtask

    task automatic test_single();
        out_ready_i = 1'b1;
        offer(1'b1, 32'hDEAD_BEEF, 16'h005A);
        tick();
        offer(1'b0, '0, '0);
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid_o); end
        n_checks++; if (out_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data got %h want deadbeef", out_data_o); end
        n_checks++; if (out_ctrl_o !== 16'h005A) begin n_fail++; $display("FAIL single_ctrl got %h want 005a", out_ctrl_o); end
        n_checks++; if (occupancy_o !== 2'd1) begin n_fail++; $display("FAIL single_occ got %0d want 1", occupancy_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %b want 0", out_valid_o); end
        n_checks++; if (out_ctrl_o !== '0) begin n_fail++; $display("FAIL single_bubble_ctrl got %h want 0", out_ctrl_o); end
        // Only the first edge (empty, ready high) was a bubble.
        n_checks++; if (bubble_cnt_o !== 4'd1) begin n_fail++; $display("FAIL single_bubble_cnt got %0d want 1", bubble_cnt_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_stream();
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(1'b1, DATA_W'(i), CTRL_W'(i + 1));
            n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready_o); end
            tick();
            n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== DATA_W'(i) || out_ctrl_o !== CTRL_W'(i + 1))
                begin n_fail++; $display("FAIL stream_out[%0d] got v=%b d=%h c=%h want v=1 d=%h c=%h", i, out_valid_o, out_data_o, out_ctrl_o, i, i + 1); end
        end
        offer(1'b0, '0, '0);
        tick();
        n_checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin n_fail++; $display("FAIL stream_end got v=%b occ=%0d want v=0 occ=0", out_valid_o, occupancy_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        offer(1'b1, 32'h11, 16'h1);
        tick();
        n_checks++; if (occupancy_o !== 2'd1) begin n_fail++; $display("FAIL bp_occ_a got %0d want 1", occupancy_o); end
        offer(1'b1, 32'h22, 16'h2);
        tick();
        offer(1'b1, 32'h33, 16'h3);
        tick();
        n_checks++; if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full got %0d want 2", occupancy_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", in_ready_o); end
        n_checks++; if (out_data_o !== 32'h11 || out_ctrl_o !== 16'h1) begin n_fail++; $display("FAIL bp_head got d=%h c=%h want d=11 c=1", out_data_o, out_ctrl_o); end
        out_ready_i = 1'b1;
        tick();
        n_checks++; if (out_data_o !== 32'h22 || occupancy_o !== 2'd1) begin n_fail++; $display("FAIL bp_second got d=%h occ=%0d want d=22 occ=1", out_data_o, occupancy_o); end
        tick();
        offer(1'b0, '0, '0);
        n_checks++; if (out_data_o !== 32'h33 || out_ctrl_o !== 16'h3 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_third got v=%b d=%h c=%h want v=1 d=33 c=3", out_valid_o, out_data_o, out_ctrl_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b want 0", out_valid_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        offer(1'b1, 32'h66, 16'h6);
        tick();
        offer(1'b1, 32'h77, 16'h7);
        tick();
        n_checks++; if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", occupancy_o); end
        flush_i = 1'b1;
        offer(1'b1, 32'h44, 16'hF);
        tick();
        flush_i = 1'b0;
        offer(1'b0, '0, '0);
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid_o); end
        n_checks++; if (out_ctrl_o !== '0) begin n_fail++; $display("FAIL flush_ctrl got %h want 0", out_ctrl_o); end
        n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occupancy_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", in_ready_o); end
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d] got v=%b d=%h want v=0", i, out_valid_o, out_data_o); end
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if (bubble_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got %0d want 15", bubble_cnt_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++; if (bubble_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_after_flush got %0d want 15", bubble_cnt_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset_two();
        out_ready_i = 1'b0;
        offer(1'b1, 32'h88, 16'h8);
        tick();
        offer(1'b1, 32'h99, 16'h9);
        tick();
        n_checks++; if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL rst2_pre_occ got %0d want 2", occupancy_o); end
        rst = 1'b1;
        offer(1'b1, 32'hAA, 16'hA);
        tick();
        rst = 1'b0;
        offer(1'b0, '0, '0);
        n_checks++; if (out_valid_o !== 1'b0 || out_ctrl_o !== '0 || out_data_o !== '0) begin n_fail++; $display("FAIL rst2_outs got v=%b c=%h d=%h want all 0", out_valid_o, out_ctrl_o, out_data_o); end
        n_checks++; if (occupancy_o !== 2'd0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst2_state got occ=%0d rdy=%b want occ=0 rdy=1", occupancy_o, in_ready_o); end
        n_checks++; if (bubble_cnt_o !== 4'd0) begin n_fail++; $display("FAIL rst2_bubble got %0d want 0", bubble_cnt_o); end
        out_ready_i = 1'b1;
        offer(1'b1, 32'h55, 16'h3);
        tick();
        offer(1'b0, '0, '0);
        n_checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h55 || occupancy_o !== 2'd1) begin n_fail++; $display("FAIL rst2_entry got v=%b d=%h occ=%0d want v=1 d=55 occ=1", out_valid_o, out_data_o, occupancy_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst2_alone got v=%b d=%h want v=0", out_valid_o, out_data_o); end
        out_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_two();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width (PC, operands, immediate, instruction).
REQ-002 The block SHALL have parameter CTRL_W, default 16, giving the control-field width (RegWrite, MemWrite, ALU_ctrl, ...).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the bubble-counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock. All state is captured on the falling edge, as for the existing pipeline registers.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush_i, input, 1 bit: kills all held entries.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: upstream entry present.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: the block can accept an entry.
REQ-009 The block SHALL have port in_ctrl_i, input, CTRL_W bits: upstream control field.
REQ-010 The block SHALL have port in_data_i, input, DATA_W bits: upstream payload.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit: entry presented downstream.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts.
REQ-013 The block SHALL have port out_ctrl_o, output, CTRL_W bits: presented control field.
REQ-014 The block SHALL have port out_data_o, output, DATA_W bits: presented payload.
REQ-015 The block SHALL have port occupancy_o, output, 2 bits: number of held entries, 0 to 2.
REQ-016 The block SHALL have port bubble_cnt_o, output, CNT_W bits: saturating count of bubble cycles.

Function
REQ-017 An input transfer SHALL occur at a sampling edge where in_valid_i=1, in_ready_o=1 and flush_i=0. An output transfer SHALL occur at an edge where out_valid_o=1 and out_ready_i=1.
REQ-018 The block SHALL hold two entries, main and skid, and use states EMPTY, ONE and TWO. occupancy_o SHALL equal 0, 1 or 2 respectively.
REQ-019 The presented outputs SHALL depend on state only:
- out_valid_o=1 in ONE and TWO.
- in_ready_o=0 only in TWO.
- Neither output SHALL depend combinationally on out_ready_i or in_valid_i.
REQ-020 In EMPTY, an input transfer SHALL load main and move to ONE.
REQ-021 In ONE, the next state SHALL be chosen as follows:
- Input and output transfer together: load main, stay in ONE.
- Input transfer only: load skid, move to TWO.
- Output transfer only: move to EMPTY.
- Neither: hold.
REQ-022 In TWO, an output transfer SHALL copy skid into main and move to ONE; otherwise the block SHALL hold.
REQ-023 The latency from input transfer to out_valid_o=1 SHALL be one edge when the block is EMPTY. Sustained throughput SHALL be one entry per cycle, and order SHALL be strictly first-in first-out.
REQ-024 out_data_o and out_ctrl_o SHALL present the main entry.
REQ-025 When out_valid_o=0, out_ctrl_o SHALL be all-zero, so that a bubble is a no-op.
REQ-026 Flush behaviour:
- flush_i=1 SHALL force EMPTY at the next edge.
- It SHALL zero the control fields of both entries.
- It SHALL drop any entry offered in that cycle.
- Payload registers MAY hold their values.
- flush_i SHALL take precedence over all transfers.
REQ-027 An output transfer coincident with flush_i SHALL still count as delivered downstream.
REQ-028 bubble_cnt_o SHALL increment at each edge where out_ready_i=1 and out_valid_o=0. It SHALL saturate at 2^CNT_W-1 and SHALL be unaffected by flush_i.
REQ-029 Payload and control SHALL pass through bit-exact; the block performs no arithmetic on them.

Reset
REQ-030 While rst=1 at an edge, the block SHALL enter EMPTY and clear main, skid and bubble_cnt_o to zero.
REQ-031 After reset: out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1.
REQ-032 rst SHALL take precedence over flush_i and all transfers. Inputs offered during reset SHALL be discarded.
REQ-033 Reset asserted mid-operation, in any state, SHALL discard all held entries with no partial output.

Structure
REQ-034 The state enum pipe_state_e (EMPTY, ONE, TWO) SHALL be placed in types_pkg, alongside DATA_BUS and ADDR_BUS.
REQ-035 The block SHALL be a single module with no sub-module. Stage-specific wrappers such as decode-to-execute SHALL instantiate it, with control signals packed into the ctrl field and payload signals into the data field.

Verification
REQ-036 Single entry: after reset, offer 0xDEADBEEF with ctrl 0x5A, out_ready_i=1. Next edge: out_valid_o=1, out_data_o=0xDEADBEEF, out_ctrl_o=0x5A, occupancy_o=1.
REQ-037 Streaming: stream data 0 to 15 back-to-back with out_ready_i=1. Required: 16 outputs in order, one per cycle, in_ready_o never 0.
REQ-038 Back-pressure: with out_ready_i=0, offer A=0x11, B=0x22 and C=0x33. Required:
- occupancy_o=2 and in_ready_o=0, with C held upstream.
- On raising out_ready_i, outputs are 0x11, 0x22, 0x33 in order with no loss or duplication.
REQ-039 Flush in TWO, with in_valid_i=1 offering 0x44. Next edge: out_valid_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1. The flushed entries and 0x44 never appear.
REQ-040 Counter saturation: with CNT_W=4, hold 20 idle cycles at out_ready_i=1. Required: bubble_cnt_o=15, and it stays 15 after a flush.
REQ-041 Reset in TWO: assert rst for one edge. Required: all outputs at reset values, and a subsequent entry 0x55 emerges alone after one edge.
